if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, owns the byte-addressed instruction memory, assembles little-endian 32-bit instructions and feeds the IF/ID pipeline register. It accepts stall from the hazard unit and redirects from branch/jump resolution in ID. A boot/run/fault state machine qualifies fetched instructions and traps illegal fetch addresses.

---
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, byte-addressed instruction memory with load port,
// little-endian word assembly and a boot/run/fault qualifier FSM.
module if_fetch_unit #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_we,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;

  logic [7:0]  mem [MEM_BYTES];

  logic        redirect;
  logic [31:0] target;
  logic        target_bad;
  logic [31:0] pc_seq;
  logic [31:0] fetch_word;

  logic [AW-3:0] rword;
  logic [AW-1:0] waddr;
  logic [AW-3:0] wword;

  // Jump outranks a simultaneous branch, so only the winning target is checked.
  always_comb begin
    redirect   = jump | branch_taken;
    target     = jump ? jump_target : branch_target;
    target_bad = (target[1:0] != 2'b00) || (target >= MemLimit);
    pc_seq     = (pc_next >= MemLimit) ? 32'h0 : pc_next;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!pc_stall) begin
          if (redirect) begin
            if (target_bad) begin
              state_d = StFault;
            end else begin
              pc_d    = target;
              count_d = count_q + 32'd1;
            end
          end else begin
            pc_d    = pc_seq;
            count_d = count_q + 32'd1;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Memory is deliberately outside the reset domain: loads land even while reset is held.
  always_comb begin
    waddr = AW'(imem_addr % MemLimit);
    wword = waddr[AW-1:2];
  end

  always_ff @(posedge clk) begin
    if (imem_we && (imem_addr[1:0] == 2'b00)) begin
      for (int i = 0; i < 4; i++) begin
        mem[{wword, 2'(i)}] <= imem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword      = pc_q[AW-1:2];
    fetch_word = {mem[{rword, 2'd3}], mem[{rword, 2'd2}], mem[{rword, 2'd1}], mem[{rword, 2'd0}]};
  end

  always_comb begin
    pc_cur      = pc_q;
    pc_next     = pc_q + 32'd4;
    valid       = (state_q == StRun);
    fault       = (state_q == StFault);
    instruction = valid ? fetch_word : 32'h0;
    fetch_count = count_q;
  end

endmodule
